sdram_op_scheduler: RTL and testbench

Upstream stage of the subroutine command generator (scg) in the SDRAM controller. Arbitrates host read/write requests, periodic auto-refresh and self-refresh entry/exit, and presents one 3-bit opcode at a time to scg, holding it until scg reports completion through its `idle` output. It also drives scg's `mode` input, which is fixed at initialization.

---
 rtl/sdram_op_scheduler.sv | 257 +++++++++++++++++++++++++
 tb/tb_sdram_op_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_op_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sdram_op_scheduler
//
// Front end of the SDRAM subroutine command generator (scg). It arbitrates
// host accesses, periodic auto-refresh and self-refresh entry/exit. It then
// presents one 3-bit opcode at a time to scg and holds it until scg signals
// completion through idle_i.
//
// Opcodes: 0 READY/SR-exit, 1 INIT, 2 SELF_REF, 3 AUTO_REF,
//          4 READ_NB, 5 READ_BRST, 6 WRITE_NB, 7 WRITE_BRST
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   h_req_i        host request level, held until h_ack_o
//   h_write_i      1 = write, 0 = read (valid with h_req_i)
//   h_burst_i      1 = burst, 0 = single (valid with h_req_i)
//   sleep_i        1 requests self-refresh, 0 requests exit
//   burst_cfg_i    burst-mode config, latched into mode_o at init start
//   idle_i         from scg, 1 = no subroutine in progress
//   opcode_o       opcode to scg
//   mode_o         latched burst_cfg_i, to scg
//   h_ack_o        one-cycle pulse when a host access completes
//   ready_o        high once the init sequence has completed
//   ref_pending_o  high while owed refreshes are outstanding
//   err_o          sticky handshake-timeout flag
// ---------------------------------------------------------------------------
module sdram_op_scheduler #(
    parameter int unsigned REF_INTERVAL = 1114,
    parameter int unsigned ACK_TIMEOUT  = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       h_req_i,
    input  logic       h_write_i,
    input  logic       h_burst_i,
    input  logic       sleep_i,
    input  logic       burst_cfg_i,
    input  logic       idle_i,
    output logic [2:0] opcode_o,
    output logic       mode_o,
    output logic       h_ack_o,
    output logic       ready_o,
    output logic       ref_pending_o,
    output logic       err_o
);

    localparam int unsigned CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0] REF_LOAD = CW'(REF_INTERVAL - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    localparam logic [2:0] OP_READY    = 3'd0;
    localparam logic [2:0] OP_INIT     = 3'd1;
    localparam logic [2:0] OP_SELF_REF = 3'd2;
    localparam logic [2:0] OP_AUTO_REF = 3'd3;

    typedef enum logic [2:0] {
        RST_WAIT,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        IDLE,
        SR_HOLD,
        SR_EXIT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    opcode_q, opcode_d;
    logic          mode_q, mode_d;
    logic          h_ack_q, h_ack_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          ref_pend_q, ref_pend_d;
    logic [1:0]    owed_q, owed_d;
    logic          force_ref_q, force_ref_d;
    logic [CW-1:0] ref_cnt_q, ref_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic ref_run;
    logic ref_expire;
    logic sr_leave;   // leaving SR_HOLD by either path
    logic ref_done;   // an AUTO_REF completed this cycle
    logic owed_dec;

    // Refresh timing is frozen before init and while scg is self-refreshing.
    assign ref_run    = ready_q && (state_q != SR_HOLD) && (state_q != SR_EXIT);
    assign ref_expire = ref_run && (ref_cnt_q == '0);

    // ------------------------------------------------------------------
    // Sequencer: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        mode_d   = mode_q;
        ready_d  = ready_q;
        err_d    = err_q;
        h_ack_d  = 1'b0;
        tmo_d    = tmo_q;
        sr_leave = 1'b0;
        ref_done = 1'b0;

        case (state_q)
            RST_WAIT: begin
                mode_d   = burst_cfg_i;
                opcode_d = OP_INIT;
                state_d  = ISSUE;
            end

            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (!idle_i) begin
                    state_d = (opcode_q == OP_SELF_REF) ? SR_HOLD : WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    // scg never took the opcode: flag it and fall back to
                    // IDLE; a host request is still pending and gets retried.
                    err_d    = 1'b1;
                    opcode_d = OP_READY;
                    state_d  = GAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            WAIT_DONE: begin
                if (idle_i) begin
                    opcode_d = OP_READY;
                    state_d  = GAP;
                    if (opcode_q == OP_INIT)     ready_d  = 1'b1;
                    if (opcode_q[2])             h_ack_d  = 1'b1;
                    if (opcode_q == OP_AUTO_REF) ref_done = 1'b1;
                end
            end

            GAP: begin
                state_d = IDLE;
            end

            IDLE: begin
                if (!ready_q) begin
                    // Only reachable after an INIT timeout: retry init.
                    opcode_d = OP_INIT;
                    state_d  = ISSUE;
                end else if ((owed_q != 2'd0) || force_ref_q || ref_expire) begin
                    // An expiry on this very edge already outranks the host.
                    opcode_d = OP_AUTO_REF;
                    state_d  = ISSUE;
                end else if (sleep_i) begin
                    opcode_d = OP_SELF_REF;
                    state_d  = ISSUE;
                end else if (h_req_i) begin
                    opcode_d = {1'b1, h_write_i, h_burst_i};
                    state_d  = ISSUE;
                end
            end

            SR_HOLD: begin
                if (!sleep_i) begin
                    opcode_d = OP_READY;
                    sr_leave = 1'b1;
                    state_d  = SR_EXIT;
                end else if (idle_i) begin
                    opcode_d = OP_READY;
                    sr_leave = 1'b1;
                    state_d  = GAP;
                end
            end

            SR_EXIT: begin
                if (idle_i) state_d = GAP;
            end

            default: state_d = RST_WAIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Refresh interval counter and owed-refresh bookkeeping
    // ------------------------------------------------------------------
    // A forced post-self-refresh AUTO_REF is consumed before the owed count.
    assign owed_dec = ref_done && !force_ref_q;

    always_comb begin
        ref_cnt_d   = ref_cnt_q;
        owed_d      = owed_q;
        force_ref_d = force_ref_q;

        if (sr_leave || ref_expire) begin
            ref_cnt_d = REF_LOAD;
        end else if (ref_run) begin
            ref_cnt_d = ref_cnt_q - 1'b1;
        end

        if (sr_leave) begin
            // Rows were refreshed by scg during self-refresh; owe nothing,
            // but insist on one AUTO_REF before the host gets back in.
            owed_d      = 2'd0;
            force_ref_d = 1'b1;
        end else begin
            if (ref_done && force_ref_q) force_ref_d = 1'b0;
            case ({ref_expire, owed_dec})
                2'b10:   if (owed_q != 2'd3) owed_d = owed_q + 2'd1;
                2'b01:   if (owed_q != 2'd0) owed_d = owed_q - 2'd1;
                default: owed_d = owed_q;  // none, or expiry cancels completion
            endcase
        end

        ref_pend_d = (owed_d != 2'd0);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RST_WAIT;
            opcode_q    <= OP_READY;
            mode_q      <= 1'b0;
            h_ack_q     <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            ref_pend_q  <= 1'b0;
            owed_q      <= 2'd0;
            force_ref_q <= 1'b0;
            ref_cnt_q   <= REF_LOAD;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            mode_q      <= mode_d;
            h_ack_q     <= h_ack_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            ref_pend_q  <= ref_pend_d;
            owed_q      <= owed_d;
            force_ref_q <= force_ref_d;
            ref_cnt_q   <= ref_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign opcode_o      = opcode_q;
    assign mode_o        = mode_q;
    assign h_ack_o       = h_ack_q;
    assign ready_o       = ready_q;
    assign ref_pending_o = ref_pend_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_sdram_op_scheduler.sv
`timescale 1ns/1ps
// Testbench for sdram_op_scheduler: directed host/refresh/sleep/timeout
// scenarios against a behavioural scg model, with an opcode/ack scoreboard.
module tb_sdram_op_scheduler;

    localparam int REF_INTERVAL = 1114;
    localparam int ACK_TIMEOUT  = 8;

    logic       clk;
    logic       rst;
    logic       h_req;
    logic       h_write;
    logic       h_burst;
    logic       sleep;
    logic       burst_cfg;
    logic       idle;
    logic [2:0] opcode;
    logic       mode;
    logic       h_ack;
    logic       ready;
    logic       ref_pending;
    logic       err;

    sdram_op_scheduler #(
        .REF_INTERVAL (REF_INTERVAL),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .h_req_i       (h_req),
        .h_write_i     (h_write),
        .h_burst_i     (h_burst),
        .sleep_i       (sleep),
        .burst_cfg_i   (burst_cfg),
        .idle_i        (idle),
        .opcode_o      (opcode),
        .mode_o        (mode),
        .h_ack_o       (h_ack),
        .ready_o       (ready),
        .ref_pending_o (ref_pending),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard queues: opcodes expected to be issued, host ops expected to ack.
    logic [2:0] exp_op_q[$];
    logic [2:0] exp_ack_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // scg model controls
    bit never_ack   = 1'b0;
    int lat         = 2;
    int busy_len    = 14290;
    int sr_exit_len = 4;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sig(input int sel);
        case (sel)
            0:       return int'(opcode);
            1:       return int'(h_ack);
            2:       return int'(ready);
            3:       return int'(err);
            default: return int'(ref_pending);
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input int val, input int max);
        bit hit = 1'b0;
        for (int i = 0; i < max && !hit; i++) begin
            @(negedge clk);
            hit = (sig(sel) == val);
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timed out after %0d cycles waiting for %0d", name, max, val);
        end
    endtask

    // ------------------------------------------------------------------
    // scg model: drops idle lat cycles after seeing an opcode, stays busy
    // busy_len cycles (self-refresh: until opcode returns to 0, then
    // sr_exit_len cycles), raises idle, then waits for the GAP.
    // ------------------------------------------------------------------
    initial begin
        logic [2:0] op;
        idle = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && opcode != 3'd0 && !never_ack) begin
                op = opcode;
                repeat (lat - 1) @(negedge clk);
                idle = 1'b0;
                if (op == 3'd2) begin
                    while (opcode != 3'd0) @(negedge clk);
                    repeat (sr_exit_len) @(negedge clk);
                end else begin
                    repeat (busy_len) @(negedge clk);
                end
                idle = 1'b1;
                while (opcode != 3'd0) @(negedge clk);
            end
        end
    end

    initial begin
        int k;
        rst       = 1'b1;
        h_req     = 1'b0;
        h_write   = 1'b0;
        h_burst   = 1'b0;
        sleep     = 1'b0;
        burst_cfg = 1'b1;

        // Monitor: compares every new opcode and every h_ack pulse with the queues.
        fork
            begin : monitor
                logic [2:0] prev_op, last_op, e;
                prev_op = 3'd0;
                last_op = 3'd0;
                forever begin
                    @(negedge clk);
                    if (opcode != prev_op && opcode != 3'd0) begin
                        chk("opcode gap before issue", int'(prev_op), 0);
                        if (exp_op_q.size() == 0) begin
                            chk("opcode issue (none expected)", int'(opcode), 0);
                        end else begin
                            e = exp_op_q.pop_front();
                            chk("opcode issue", int'(opcode), int'(e));
                        end
                        last_op = opcode;
                    end
                    if (h_ack) begin
                        if (exp_ack_q.size() == 0) begin
                            chk("h_ack (none expected)", int'(h_ack), 0);
                        end else begin
                            e = exp_ack_q.pop_front();
                            chk("h_ack for opcode", int'(last_op), int'(e));
                        end
                    end
                    prev_op = opcode;
                end
            end
        join_none

        // ---- reset state -------------------------------------------------
        repeat (3) @(negedge clk);
        chk("reset opcode", opcode, 0);
        chk("reset mode", mode, 0);
        chk("reset ready", ready, 0);
        chk("reset err", err, 0);
        chk("reset h_ack", h_ack, 0);
        chk("reset ref_pending", ref_pending, 0);

        // ---- init ----------------------------------------------------------
        exp_op_q.push_back(3'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("init mode", mode, 1);
        chk("init opcode", opcode, 1);
        wait_for("init ready", 2, 1, 14400);
        chk("opcode in init gap", opcode, 0);
        chk("ref_pending after init", ref_pending, 0);

        // ---- host write burst ---------------------------------------------
        busy_len = 5;
        exp_op_q.push_back(3'd7);
        exp_ack_q.push_back(3'd7);
        h_write = 1'b1; h_burst = 1'b1; h_req = 1'b1;
        wait_for("write burst ack", 1, 1, 100);
        h_req = 1'b0;
        chk("opcode in host gap", opcode, 0);
        @(negedge clk);
        chk("h_ack single pulse", h_ack, 0);
        chk("opcode after host gap", opcode, 0);

        // ---- refresh expiry while a read request is held -------------------
        // A 1200-cycle write spans the first expiry (REF_INTERVAL after ready).
        busy_len = 1200;
        exp_op_q.push_back(3'd6);
        exp_ack_q.push_back(3'd6);
        h_write = 1'b1; h_burst = 1'b0; h_req = 1'b1;
        wait_for("long write ack", 1, 1, 2000);
        busy_len = 5;
        h_write = 1'b0; h_burst = 1'b0;   // request stays up, now a single read
        chk("ref_pending after expiry", ref_pending, 1);
        exp_op_q.push_back(3'd3);
        exp_op_q.push_back(3'd4);
        exp_ack_q.push_back(3'd4);
        wait_for("read after refresh ack", 1, 1, 200);
        h_req = 1'b0;
        chk("ref_pending after refresh", ref_pending, 0);

        // ---- self-refresh entry / exit -----------------------------------
        exp_op_q.push_back(3'd2);
        sleep = 1'b1;
        wait_for("self-refresh issue", 0, 2, 50);
        repeat (20) @(negedge clk);
        chk("self-refresh held", opcode, 2);
        exp_op_q.push_back(3'd3);
        exp_op_q.push_back(3'd7);
        exp_ack_q.push_back(3'd7);
        h_write = 1'b1; h_burst = 1'b1; h_req = 1'b1;
        sleep = 1'b0;
        wait_for("self-refresh exit", 0, 0, 5);
        chk("sr-exit opcode", opcode, 0);
        wait_for("post-sleep host ack", 1, 1, 200);
        h_req = 1'b0;

        // ---- owed-count saturation ---------------------------------------
        // Counter reloaded on SR exit; a 4*REF_INTERVAL+500 block sees four
        // expiries and ends well clear of the fifth.
        busy_len = 4 * REF_INTERVAL + 500;
        exp_op_q.push_back(3'd6);
        exp_ack_q.push_back(3'd6);
        h_write = 1'b1; h_burst = 1'b0; h_req = 1'b1;
        wait_for("blocking write ack", 1, 1, 6000);
        h_req = 1'b0;
        busy_len = 5;
        chk("ref_pending while owed", ref_pending, 1);
        exp_op_q.push_back(3'd3);
        exp_op_q.push_back(3'd3);
        exp_op_q.push_back(3'd3);
        wait_for("owed refreshes drained", 4, 0, 300);
        repeat (100) @(negedge clk);
        chk("exactly three refreshes", exp_op_q.size(), 0);

        // ---- handshake timeout and retry ---------------------------------
        never_ack = 1'b1;
        exp_op_q.push_back(3'd5);
        exp_op_q.push_back(3'd5);
        exp_ack_q.push_back(3'd5);
        h_write = 1'b0; h_burst = 1'b1; h_req = 1'b1;
        wait_for("timeout issue", 0, 5, 20);
        k = 0;
        while (!err && k < 20) begin
            @(negedge clk);
            k++;
        end
        // one ISSUE cycle plus ACK_TIMEOUT cycles in WAIT_BUSY
        chk("err latency", k, ACK_TIMEOUT + 1);
        never_ack = 1'b0;
        chk("err set", err, 1);
        chk("opcode after timeout", opcode, 0);
        wait_for("retried read ack", 1, 1, 100);
        h_req = 1'b0;
        chk("err sticky", err, 1);

        // ---- reset mid-access --------------------------------------------
        busy_len = 200;
        exp_op_q.push_back(3'd4);
        h_write = 1'b0; h_burst = 1'b0; h_req = 1'b1;
        wait_for("mid-access issue", 0, 4, 20);
        repeat (10) @(negedge clk);
        chk("opcode mid-access", opcode, 4);
        rst = 1'b1;
        h_req = 1'b0;
        @(negedge clk);
        chk("mid reset opcode", opcode, 0);
        chk("mid reset ready", ready, 0);
        chk("mid reset err", err, 0);
        chk("mid reset h_ack", h_ack, 0);
        chk("mid reset mode", mode, 0);
        chk("mid reset ref_pending", ref_pending, 0);

        repeat (3) @(negedge clk);
        chk("opcodes left unissued", exp_op_q.size(), 0);
        chk("acks left unseen", exp_ack_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
